// File: rtl/io_word_bridge_if.sv
`default_nettype none
// ============================================================================
// io_word_bridge_if : CPU request/response and UART IO byte-stage signals
// Revision: 1.0
// ============================================================================
interface io_word_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_word;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        io_ren;
  logic [7:0]  io_rdata;
  logic        io_rbusy;
  logic        io_rdone;
  logic        io_wen;
  logic [7:0]  io_wdata;
  logic        io_wbusy;
  logic        io_wdone;

  // Environment side: CPU requester plus the UART IO stage.
  modport master (
    output req_valid, req_we, req_word, req_wdata,
    output io_rdata, io_rbusy, io_rdone, io_wbusy, io_wdone,
    input  req_ready, resp_valid, resp_rdata, io_ren, io_wen, io_wdata
  );

  modport slave (
    input  req_valid, req_we, req_word, req_wdata,
    input  io_rdata, io_rbusy, io_rdone, io_wbusy, io_wdone,
    output req_ready, resp_valid, resp_rdata, io_ren, io_wen, io_wdata
  );
endinterface
`default_nettype wire

// File: rtl/io_word_bridge.sv
`default_nettype none
// ============================================================================
// io_word_bridge : splits 32-bit / 8-bit CPU transfers into UART IO byte ops
// Revision: 1.0
// ============================================================================
module io_word_bridge #(
  parameter int MSB_FIRST = 1
) (
  input  wire logic       clk,
  input  wire logic       rstn,
  io_word_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    WR_WAIT  = 3'd4,
    RESP     = 3'd5
  } state_t;

  state_t      r_state;
  logic        r_word;
  logic [31:0] r_wdata;
  logic [2:0]  r_count;
  logic [31:0] r_asm;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_io_ren;
  logic        r_io_wen;
  logic [7:0]  r_io_wdata;

  logic [1:0]  w_wr_idx;
  logic [1:0]  w_rd_idx;
  logic [7:0]  w_wr_byte;
  logic [31:0] w_asm_next;

  // Byte lane selection; r_count holds the bytes still to move (4..1).
  always_comb begin
    w_wr_idx = 2'd0;
    if (r_word) begin
      w_wr_idx = (MSB_FIRST != 0) ? 2'(r_count - 3'd1) : 2'(3'd4 - r_count);
    end
    w_rd_idx  = 2'(3'd4 - r_count);
    w_wr_byte = r_wdata[{w_wr_idx, 3'b000} +: 8];
    w_asm_next = r_asm;
    if (MSB_FIRST != 0) begin
      w_asm_next = {r_asm[23:0], bus.io_rdata};
    end else begin
      w_asm_next[{w_rd_idx, 3'b000} +: 8] = bus.io_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_word       <= 1'b0;
      r_wdata      <= 32'h0;
      r_count      <= 3'd0;
      r_asm        <= 32'h0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_io_ren     <= 1'b0;
      r_io_wen     <= 1'b0;
      r_io_wdata   <= 8'h0;
    end else begin
      r_io_ren     <= 1'b0;
      r_io_wen     <= 1'b0;
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_word      <= bus.req_word;
            r_wdata     <= bus.req_wdata;
            r_count     <= bus.req_word ? 3'd4 : 3'd1;
            r_asm       <= 32'h0;
            r_req_ready <= 1'b0;
            r_state     <= bus.req_we ? WR_ISSUE : RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (!bus.io_rbusy) begin
            r_io_ren <= 1'b1;
            r_state  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bus.io_rdone) begin
            r_asm   <= w_asm_next;
            r_count <= r_count - 3'd1;
            if (r_count == 3'd1) begin
              r_resp_valid <= 1'b1;
              r_resp_rdata <= r_word ? w_asm_next : {24'h0, bus.io_rdata};
              r_state      <= RESP;
            end else begin
              r_state <= RD_ISSUE;
            end
          end
        end
        WR_ISSUE: begin
          if (!bus.io_wbusy) begin
            r_io_wdata <= w_wr_byte;
            r_io_wen   <= 1'b1;
            r_state    <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (bus.io_wdone) begin
            r_count <= r_count - 3'd1;
            if (r_count == 3'd1) begin
              r_resp_valid <= 1'b1;
              r_resp_rdata <= 32'h0;
              r_state      <= RESP;
            end else begin
              r_state <= WR_ISSUE;
            end
          end
        end
        RESP: begin
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.io_ren     = r_io_ren;
  assign bus.io_wen     = r_io_wen;
  assign bus.io_wdata   = r_io_wdata;

endmodule
`default_nettype wire
